// File: rtl/intt_input_loader.sv
// intt_input_loader: buffers one serial polynomial of 2^LOG_N coefficients and
// replays it as per-core, two-slot packed rows wrapped in the intt_processor
// start protocol. A new frame is accepted only after the previous one streamed.
module intt_input_loader #(
    parameter int LOG_N          = 12,
    parameter int LOG_CORE_COUNT = 4,
    parameter int COEFF_WIDTH    = 30
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [COEFF_WIDTH-1:0]        in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    input  logic                          proc_ready,
    output logic                          start,
    output logic [(1<<LOG_CORE_COUNT)-1:0][1:0][2*COEFF_WIDTH-1:0] data_out,
    output logic                          busy,
    output logic                          frame_err
);

    localparam int C        = 1 << LOG_CORE_COUNT;
    localparam int LOG_ROWS = LOG_N - 2 - LOG_CORE_COUNT;
    localparam int ROWS     = 1 << LOG_ROWS;
    localparam int WW       = 2 * COEFF_WIDTH;
    localparam int WORDS    = 1 << (LOG_N - 1);

    localparam logic [LOG_N-1:0]  LAST_BEAT = {LOG_N{1'b1}};
    localparam logic [LOG_N-1:0]  BEAT_ONE  = LOG_N'(1);
    localparam logic [LOG_ROWS:0] ROW_END   = (LOG_ROWS + 1)'(ROWS);
    localparam logic [LOG_ROWS:0] ROW_ONE   = (LOG_ROWS + 1)'(1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t                   state_q;
    logic [LOG_N-1:0]         beat_q;
    logic [LOG_ROWS:0]        row_q;
    logic                     start_q;
    logic                     in_ready_q;
    logic                     busy_q;
    logic                     frame_err_q;
    logic [COEFF_WIDTH-1:0]   half_q;
    logic [WW-1:0]            mem_q [0:WORDS-1];
    logic [C*2*WW-1:0]        dout_q;
    logic [C*2*WW-1:0]        rd_next_d;

    logic accept_s;
    logic last_beat_s;
    logic rd_en_s;

    // in_ready_q is only ever high in FILL, so it also qualifies the state
    assign accept_s    = in_valid & in_ready_q;
    assign last_beat_s = (beat_q == LAST_BEAT);
    assign rd_en_s     = (state_q == ST_STREAM) && (row_q != ROW_END);

    assign in_ready  = in_ready_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign data_out  = dout_q;

    // Control FSM: beat counting, handshake, start protocol and framing check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            beat_q      <= '0;
            row_q       <= '0;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (accept_s && (in_last != last_beat_s)) begin
                frame_err_q <= 1'b1;
            end
            case (state_q)
                ST_FILL: begin
                    if (accept_s && last_beat_s) begin
                        state_q    <= ST_WAIT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        beat_q     <= '0;
                    end else if (accept_s) begin
                        beat_q     <= beat_q + BEAT_ONE;
                        in_ready_q <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (proc_ready) begin
                        state_q <= ST_STREAM;
                        start_q <= 1'b1;
                        row_q   <= '0;
                    end
                end
                ST_STREAM: begin
                    // The replay never pauses; proc_ready is ignored here
                    if (row_q == ROW_END) begin
                        state_q    <= ST_FILL;
                        start_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        row_q      <= '0;
                        beat_q     <= '0;
                    end else begin
                        row_q <= row_q + ROW_ONE;
                    end
                end
                default: begin
                    state_q    <= ST_FILL;
                    start_q    <= 1'b0;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                    row_q      <= '0;
                    beat_q     <= '0;
                end
            endcase
        end
    end

    // Buffer write: even coefficient parks in half_q, odd one commits the word
    always_ff @(posedge clk) begin
        if (accept_s) begin
            if (beat_q[0]) begin
                mem_q[beat_q[LOG_N-1:1]] <= {in_data, half_q};
            end else begin
                half_q <= in_data;
            end
        end
    end

    // Gather row row_q from every bank; word address is {slot, core, row}
    always_comb begin
        rd_next_d = '0;
        for (int k = 0; k < C; k++) begin
            for (int s = 0; s < 2; s++) begin
                rd_next_d[(k*2+s)*WW +: WW] =
                    mem_q[{1'(s), LOG_CORE_COUNT'(k), row_q[LOG_ROWS-1:0]}];
            end
        end
    end

    // Registered bank read; output is forced to zero outside the row cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_en_s) begin
            dout_q <= rd_next_d;
        end else begin
            dout_q <= '0;
        end
    end

endmodule

// File: tb/tb_intt_input_loader.sv
// Self-checking bench for intt_input_loader: expected rows are queued when a
// frame is driven and popped by a monitor on every cycle start is high.
module tb_intt_input_loader;

    localparam int N    = 4096;
    localparam int C    = 16;
    localparam int ROWS = 64;

    typedef logic [C-1:0][1:0][59:0] row_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [29:0]      in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             proc_ready;
    logic             start;
    row_t             data_out;
    logic             busy;
    logic             frame_err;

    int   vectors     = 0;
    int   miscompares = 0;
    row_t exp_q[$];
    row_t exp_row;
    int   run_len     = 0;
    int   spot_mode   = 0;   // 0 none, 1 ramp, 2 reversed ramp

    intt_input_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .proc_ready (proc_ready),
        .start      (start),
        .data_out   (data_out),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] coef(input bit rev, input int c);
        return rev ? 30'(4095 - c) : 30'(c);
    endfunction

    // Expected replay: a zero row, then rows 0..ROWS-1
    task automatic push_frame(input bit rev);
        row_t v;
        int   w;
        v = '0;
        exp_q.push_back(v);
        for (int i = 0; i < ROWS; i++) begin
            for (int k = 0; k < C; k++) begin
                for (int s = 0; s < 2; s++) begin
                    w = s * (N / 4) + k * ROWS + i;
                    v[k][s] = {coef(rev, 2*w + 1), coef(rev, 2*w)};
                end
            end
            exp_q.push_back(v);
        end
    endtask

    // Drive one frame; returns #1 after the edge that accepted beat N-1
    task automatic send_frame(input bit rev, input bit bubbles, input bit bad_framing);
        int c     = 0;
        int guard = 0;
        bit acc;
        push_frame(rev);
        while (c < N && guard < 20000) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = coef(rev, c);
            in_last  = bad_framing ? (c == 100) : (c == N - 1);
            acc      = in_valid && in_ready;
            if (bad_framing && acc && c == 100) chk("frame_err_before", frame_err, 0);
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                c++;
                if (bad_framing && c == 101) chk("frame_err_set", frame_err, 1);
            end
        end
        if (c < N) chk("fill_timeout", c, N);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!start && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("start_seen", start, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        #1;
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_start", start, 0);
    endtask

    // Monitor: score every start cycle against the queue, check burst length
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else if (start) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                exp_row = exp_q.pop_front();
                for (int k = 0; k < C; k++) begin
                    for (int s = 0; s < 2; s++) begin
                        chk($sformatf("r%0d_k%0d_s%0d", run_len, k, s), data_out[k][s], exp_row[k][s]);
                    end
                end
            end
            if (spot_mode == 1 && run_len == 1) begin
                chk("ramp_r0_k0_s0", data_out[0][0], {30'd1, 30'd0});
                chk("ramp_r0_k0_s1", data_out[0][1], {30'd2049, 30'd2048});
            end
            if (spot_mode == 1 && run_len == 6)  chk("ramp_r5_k3_s0", data_out[3][0], {30'd395, 30'd394});
            if (spot_mode == 1 && run_len == 64) chk("ramp_r63_k15_s1", data_out[15][1], {30'd4095, 30'd4094});
            if (spot_mode == 2 && run_len == 1)  chk("rev_r0_k0_s0", data_out[0][0], {30'd4094, 30'd4095});
            run_len = run_len + 1;
        end else if (run_len != 0) begin
            chk("start_len", run_len, ROWS + 1);
            chk("dout_idle", data_out == '0, 1);
            run_len = 0;
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = 30'd0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        proc_ready = 1'b1;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_start", start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_dout", data_out == '0, 1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // Ramp frame, processor idle: start one cycle after the last beat
        spot_mode = 1;
        send_frame(1'b0, 1'b0, 1'b0);
        chk("wait_start_low", start, 0);
        chk("wait_busy", busy, 1);
        chk("wait_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("start_latency", start, 1);
        wait_drain();

        // Backpressure: processor busy during load plus 20 cycles
        proc_ready = 1'b0;
        send_frame(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
            chk("bp_start", start, 0);
        end
        proc_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_start_rise", start, 1);
        wait_drain();

        // Input bubbles at ~50% duty
        send_frame(1'b0, 1'b1, 1'b0);
        wait_drain();

        // Framing error: early in_last, missing final in_last
        spot_mode = 0;
        send_frame(1'b0, 1'b0, 1'b1);
        chk("frame_err_end", frame_err, 1);
        wait_drain();

        // Next frame keeps the sticky error; reset lands at stream row 30
        send_frame(1'b0, 1'b0, 1'b0);
        chk("frame_err_sticky", frame_err, 1);
        wait_start();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_start", start, 0);
        chk("midrst_dout", data_out == '0, 1);
        chk("midrst_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        chk("midrst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reversed ramp after reset must start again at index 0
        spot_mode = 2;
        send_frame(1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("final_frame_err", frame_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intt_input_loader.md
# intt_input_loader

Upstream feeder for `intt_processor`. It accepts one polynomial of 2^LOG_N 30-bit coefficients as a serial valid/ready stream in natural index order, and buffers the whole polynomial on chip. It then replays the coefficients as the per-core, two-slot, 60-bit packed rows that `intt_processor` expects, wrapped in its `start` protocol. A new polynomial is accepted only after the previous one has been fully streamed out.

## Interface
- `LOG_N`, 12, log2 of polynomial length N.
- `LOG_CORE_COUNT`, 4, log2 of core count C; must match `intt_processor`.
- `COEFF_WIDTH`, 30, coefficient width; packed word is 2*COEFF_WIDTH.
- Derived: ROWS = 2^(LOG_N-2-LOG_CORE_COUNT) (64 at defaults).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  COEFF_WIDTH  coefficient, index order 0..N-1.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  marks the final coefficient of a frame.
- `in_ready`  out  1  loader accepts a beat when `in_valid & in_ready`.
- `proc_ready`  in  1  downstream processor idle; level-sensitive.
- `start`  out  1  drives `intt_processor.start`.
- `data_out[C-1:0][1:0]`  out  2*COEFF_WIDTH  drives `intt_processor.data_in`.
- `busy`  out  1  high in WAIT or STREAM.
- `frame_err`  out  1  sticky flag for `in_last` framing error.

## Operation
- Packing: word w holds coefficient 2w in bits [29:0] and coefficient 2w+1 in bits [59:30]. There are N/2 words.
- Mapping: word w goes to slot s = w / (C*ROWS), core k = (w / ROWS) mod C, row i = w mod ROWS. At defaults: s = w[10], k = w[9:6], i = w[5:0]. Equivalently, in row i, `data_out[k][0]` = word k*ROWS+i and `data_out[k][1]` = word k*ROWS+i+N/4.
- Storage: 2*C banks, each ROWS x 60 bits, with a registered read (1-cycle latency).
- Even coefficients are held in a half-word register. When the odd coefficient arrives, the full 60-bit word is written.
- FSM:
  - FILL: `in_ready`=1. A 12-bit beat counter increments on each accepted beat. At beat N-1, go to WAIT.
  - WAIT: `in_ready`=0. Go to STREAM on the first cycle `proc_ready`=1. If `proc_ready` is already 1 on entry, STREAM begins the next cycle.
  - STREAM: row counter j runs 0..ROWS. After j=ROWS, return to FILL and clear the beat counter.
- `in_last` check: `frame_err` is set if `in_last`=1 on an accepted beat other than N-1, or if `in_last`=0 on beat N-1. Framing still follows the count, not `in_last`. `frame_err` is cleared only by reset.
- `proc_ready` is ignored during STREAM; the replay is never paused.

## Timing
- Reset values (asynchronous): state=FILL, both counters 0, `start`=0, all `data_out`=0, `frame_err`=0, `busy`=0. `in_ready`=1 from the first clock edge after `rst_n` rises. Buffer contents are don't-care.
- STREAM cycle j=0: `start`=1, `data_out`=0.
- STREAM cycles j=1..ROWS: `start`=1, `data_out` = row j-1, registered with each row stable for exactly one cycle.
- Cycle after j=ROWS: `start`=0, `data_out`=0, state=FILL, `in_ready`=1.
- `start` is therefore high for ROWS+1 consecutive cycles (65 at defaults).
- Minimum frame period is N + 1 + ROWS + 1 cycles (4162 at defaults) with no input bubbles and `proc_ready`=1.
- `in_valid` bubbles stall the beat counter only; no data is lost. `in_data` and `in_last` are don't-care when `in_valid`=0.
- Reset mid-FILL or mid-STREAM: `start`, `data_out` and `busy` clear immediately. The partial frame is discarded and the next frame starts at index 0.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release.
  - During reset: `start`=0, `busy`=0, `frame_err`=0, all `data_out`=0.
  - First edge after release: `in_ready`=1.
- Ramp frame, coefficient c = c, `proc_ready`=1:
  - `start` rises 1 cycle after beat 4095 and stays high 65 cycles.
  - Row 0: `data_out[0][0]` = {1,0}, `data_out[0][1]` = {2049,2048}.
  - Row 63: `data_out[15][1]` = {4095,4094}.
  - Row 5: `data_out[3][0]` = {395,394} (word 197).
- Backpressure: `proc_ready`=0 while the ramp frame is loaded, then held 0 for 20 more cycles.
  - `in_ready`=0 and `busy`=1 during the hold; `start`=0.
  - `start`=1 on the cycle after `proc_ready` rises.
- Input bubbles: ramp frame with pseudo-random `in_valid` at about 50% duty.
  - All 65 rows match the ramp case bit-exactly.
- Framing: assert `in_last` on beat 100 and deassert it on beat 4095.
  - `frame_err`=1 from beat 101 onward.
  - Streaming still occurs after beat 4095.
  - `frame_err` stays 1 into the next frame until reset.
- Reset mid-stream: assert `rst_n`=0 at STREAM row 30.
  - `start`=0 and `data_out`=0 within the same cycle.
  - After release, a new frame with coefficient c = 4095-c streams row 0 `data_out[0][0]` = {4094,4095}.
